// File: rtl/cordic_microrot_replay_ctrl_pkg.sv
// Shared types and helpers for the CORDIC micro-rotation replay controller:
// FSM encoding, FIFO entry field widths and replay-count normalisation.
package cordic_microrot_replay_ctrl_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

  localparam int QUAD_W = 2;

  function automatic int cnt_width(input int num_ch);
    return $clog2(num_ch + 1);
  endfunction

  function automatic int idx_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  function automatic int entry_width(input int stages, input int num_ch);
    return stages + QUAD_W + cnt_width(num_ch);
  endfunction

  // A replay count of 0, or one larger than the channel budget, means "all channels".
  function automatic int unsigned norm_count(input int unsigned cnt, input int unsigned num_ch);
    return (cnt == 0 || cnt > num_ch) ? num_ch : cnt;
  endfunction

endpackage

// File: rtl/cordic_microrot_replay_ctrl_if.sv
// Bus bundle between the vectoring core / sample source and the replay
// controller, plus the replayed stream towards the rotation core.
interface cordic_microrot_replay_ctrl_if
  import cordic_microrot_replay_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int CORDIC_STAGES = 16,
  parameter int NUM_CH        = 4
) ();

  localparam int CW = cnt_width(NUM_CH);
  localparam int IW = idx_width(NUM_CH);

  logic                     vec_opvld_in;
  logic [CORDIC_STAGES-1:0] vec_microRot_dir_in;
  logic [QUAD_W-1:0]        vec_quad_in;
  logic [CW-1:0]            vec_ch_count_in;

  logic                     s_valid;
  logic                     s_ready;
  logic [DATA_WIDTH-1:0]    s_xin;
  logic [DATA_WIDTH-1:0]    s_yin;

  logic                     rot_en_out;
  logic [DATA_WIDTH-1:0]    rot_xin_out;
  logic [DATA_WIDTH-1:0]    rot_yin_out;
  logic [QUAD_W-1:0]        rot_quad_out;
  logic [CORDIC_STAGES-1:0] rot_microRot_out;
  logic [IW-1:0]            ch_idx_out;
  logic                     last_out;

  modport master (
    output vec_opvld_in, vec_microRot_dir_in, vec_quad_in, vec_ch_count_in,
    output s_valid, s_xin, s_yin,
    input  s_ready,
    input  rot_en_out, rot_xin_out, rot_yin_out, rot_quad_out, rot_microRot_out,
    input  ch_idx_out, last_out
  );

  modport slave (
    input  vec_opvld_in, vec_microRot_dir_in, vec_quad_in, vec_ch_count_in,
    input  s_valid, s_xin, s_yin,
    output s_ready,
    output rot_en_out, rot_xin_out, rot_yin_out, rot_quad_out, rot_microRot_out,
    output ch_idx_out, last_out
  );

endinterface

// File: rtl/cordic_dir_fifo.sv
// Small synchronous FIFO for direction words. A push while full is still
// accepted when a pop happens in the same cycle; otherwise it sets a sticky flag.
module cordic_dir_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      level_reg;
  logic             overflow_reg;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level_reg == '0);
  assign full    = (level_reg == FULL_LVL);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_reg[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level_reg <= level_reg + (AW+1)'(1);
        2'b01:   level_reg <= level_reg - (AW+1)'(1);
        default: level_reg <= level_reg;
      endcase
      if (push && !do_push) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  // Head is read combinationally so the controller can pop and use a word in one cycle.
  assign head     = mem_reg[rd_ptr_reg];
  assign level    = level_reg;
  assign overflow = overflow_reg;

endmodule

// File: rtl/cordic_microrot_replay_ctrl.sv
// Replays each buffered vectoring direction word onto up to NUM_CH (x,y)
// channel pairs for a pipelined rotation core, with optional per-stage bit skew.
module cordic_microrot_replay_ctrl
  import cordic_microrot_replay_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int CORDIC_STAGES = 16,
  parameter int NUM_CH        = 4,
  parameter int FIFO_DEPTH    = 4,
  parameter int SKEW_OUT      = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  cordic_microrot_replay_ctrl_if.slave bus,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow_err,
  output logic                        busy
);

  localparam int CW = cnt_width(NUM_CH);
  localparam int IW = idx_width(NUM_CH);
  localparam int EW = entry_width(CORDIC_STAGES, NUM_CH);

  state_t                   state_reg, state_next;
  logic [IW-1:0]            cnt_reg, cnt_next;
  logic [CORDIC_STAGES-1:0] act_dir_reg;
  logic [QUAD_W-1:0]        act_quad_reg;
  logic [CW-1:0]            act_cnt_reg;

  logic [EW-1:0]            wr_entry;
  logic [EW-1:0]            head;
  logic                     fifo_empty;
  logic                     pop;
  logic [CW-1:0]            norm_cnt;
  logic                     s_ready_int;
  logic                     hs;
  logic                     last_beat;

  logic                     en_reg;
  logic [DATA_WIDTH-1:0]    x_reg;
  logic [DATA_WIDTH-1:0]    y_reg;
  logic [QUAD_W-1:0]        quad_reg;
  logic [IW-1:0]            idx_reg;
  logic                     last_reg;
  logic [CORDIC_STAGES-1:0] dir_reg;
  logic [CORDIC_STAGES-1:0] dir_out;

  assign norm_cnt = CW'(norm_count(32'(bus.vec_ch_count_in), NUM_CH));
  assign wr_entry = {bus.vec_microRot_dir_in, bus.vec_quad_in, norm_cnt};

  cordic_dir_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (bus.vec_opvld_in),
    .push_data (wr_entry),
    .pop       (pop),
    .head      (head),
    .empty     (fifo_empty),
    .level     (fifo_level),
    .overflow  (overflow_err)
  );

  assign s_ready_int = (state_reg == ST_ISSUE);
  assign hs          = s_ready_int && bus.s_valid;
  assign last_beat   = ((CW'(cnt_reg) + CW'(1)) == act_cnt_reg);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    pop        = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          cnt_next   = '0;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (hs) begin
          if (last_beat) begin
            cnt_next = '0;
            // Chain straight into the next queued word so replay has no bubble.
            if (!fifo_empty) begin
              pop = 1'b1;
            end else begin
              state_next = ST_IDLE;
            end
          end else begin
            cnt_next = cnt_reg + IW'(1);
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      act_dir_reg  <= '0;
      act_quad_reg <= '0;
      act_cnt_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (pop) begin
        act_dir_reg  <= head[EW-1 -: CORDIC_STAGES];
        act_quad_reg <= head[CW +: QUAD_W];
        act_cnt_reg  <= head[CW-1:0];
      end
    end
  end

  // Issued beat registers; everything except the strobe holds between beats.
  always_ff @(posedge clk) begin
    if (reset) begin
      en_reg   <= 1'b0;
      x_reg    <= '0;
      y_reg    <= '0;
      quad_reg <= '0;
      idx_reg  <= '0;
      last_reg <= 1'b0;
      dir_reg  <= '0;
    end else begin
      en_reg <= hs;
      if (hs) begin
        x_reg    <= bus.s_xin;
        y_reg    <= bus.s_yin;
        quad_reg <= act_quad_reg;
        idx_reg  <= cnt_reg;
        last_reg <= last_beat;
        dir_reg  <= act_dir_reg;
      end
    end
  end

  genvar gi;
  generate
    if (SKEW_OUT != 0) begin : g_skew
      for (gi = 0; gi < CORDIC_STAGES; gi++) begin : g_bit
        if (gi == 0) begin : g_direct
          assign dir_out[gi] = dir_reg[gi];
        end else begin : g_line
          // Bit gi travels through gi flops so it meets rotation stage gi.
          logic line_reg [gi];
          always_ff @(posedge clk) begin
            if (reset) begin
              for (int k = 0; k < gi; k++) begin
                line_reg[k] <= 1'b0;
              end
            end else begin
              line_reg[0] <= dir_reg[gi];
              for (int k = 1; k < gi; k++) begin
                line_reg[k] <= line_reg[k-1];
              end
            end
          end
          assign dir_out[gi] = line_reg[gi-1];
        end
      end
    end else begin : g_aligned
      assign dir_out = dir_reg;
    end
  endgenerate

  assign bus.s_ready          = s_ready_int;
  assign bus.rot_en_out       = en_reg;
  assign bus.rot_xin_out      = x_reg;
  assign bus.rot_yin_out      = y_reg;
  assign bus.rot_quad_out     = quad_reg;
  assign bus.ch_idx_out       = idx_reg;
  assign bus.last_out         = last_reg;
  assign bus.rot_microRot_out = dir_out;
  assign busy                 = !fifo_empty || (state_reg != ST_IDLE);

endmodule

// File: tb/tb_cordic_microrot_replay_ctrl.sv
// Directed + randomized bench for cordic_microrot_replay_ctrl against a
// queue-based transaction model of the replay rules.
module tb_cordic_microrot_replay_ctrl;
  import cordic_microrot_replay_ctrl_pkg::*;

  localparam int DW   = 16;
  localparam int ST   = 16;
  localparam int NCH  = 4;
  localparam int FD   = 4;
  localparam int SKEW = 1;
  localparam int CW   = cnt_width(NCH);

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [$clog2(FD):0]  fifo_level;
  logic                 overflow_err;
  logic                 busy;

  cordic_microrot_replay_ctrl_if #(.DATA_WIDTH(DW), .CORDIC_STAGES(ST), .NUM_CH(NCH)) bus ();

  cordic_microrot_replay_ctrl #(
    .DATA_WIDTH(DW), .CORDIC_STAGES(ST), .NUM_CH(NCH), .FIFO_DEPTH(FD), .SKEW_OUT(SKEW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .fifo_level   (fifo_level),
    .overflow_err (overflow_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit checking = 0;

  task automatic check_eq(input string tag, input longint unsigned got, input longint unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 100)
        $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [ST-1:0] dir;
    logic [1:0]    quad;
    int            cnt;
  } word_t;

  word_t          q[$];
  word_t          m_cur;
  word_t          w_new;
  bit             m_active;
  int             m_idx;
  bit             m_ovf;
  bit             m_hs;
  bit             e_en;
  logic [DW-1:0]  e_x, e_y;
  logic [1:0]     e_quad;
  int             e_idx;
  bit             e_last;
  logic [ST-1:0]  e_dir;
  logic [ST-1:0]  hist[$];

  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      m_active = 0; m_idx = 0; m_ovf = 0;
      e_en = 0; e_x = '0; e_y = '0; e_quad = '0; e_idx = 0; e_last = 0; e_dir = '0;
      hist.delete();
      for (int i = 0; i < ST; i++) hist.push_back('0);
    end else begin
      m_hs = m_active && bus.s_valid;
      e_en = m_hs;
      if (m_hs) begin
        e_x = bus.s_xin; e_y = bus.s_yin;
        e_quad = m_cur.quad; e_dir = m_cur.dir;
        e_idx = m_idx;
        e_last = (m_idx == m_cur.cnt - 1);
        if (e_last) begin
          m_idx = 0;
          if (q.size() > 0) m_cur = q.pop_front();
          else m_active = 0;
        end else begin
          m_idx++;
        end
      end else if (!m_active && q.size() > 0) begin
        m_cur = q.pop_front();
        m_active = 1;
        m_idx = 0;
      end
      if (bus.vec_opvld_in) begin
        if (q.size() < FD) begin
          w_new.dir  = bus.vec_microRot_dir_in;
          w_new.quad = bus.vec_quad_in;
          w_new.cnt  = (bus.vec_ch_count_in == 0 || int'(bus.vec_ch_count_in) > NCH)
                       ? NCH : int'(bus.vec_ch_count_in);
          q.push_back(w_new);
        end else begin
          m_ovf = 1;
        end
      end
      hist.push_back(e_dir);
      void'(hist.pop_front());
    end
  end

  function automatic logic [ST-1:0] exp_dir_out();
    logic [ST-1:0] r;
    logic [ST-1:0] h;
    for (int i = 0; i < ST; i++) begin
      h = hist[ST-1-i];
      r[i] = (SKEW != 0) ? h[i] : e_dir[i];
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (checking) begin
      check_eq("s_ready",  bus.s_ready, m_active);
      check_eq("rot_en",   bus.rot_en_out, e_en);
      check_eq("rot_x",    bus.rot_xin_out, e_x);
      check_eq("rot_y",    bus.rot_yin_out, e_y);
      check_eq("rot_quad", bus.rot_quad_out, e_quad);
      check_eq("ch_idx",   bus.ch_idx_out, e_idx);
      check_eq("last",     bus.last_out, e_last);
      check_eq("dir_out",  bus.rot_microRot_out, exp_dir_out());
      check_eq("level",    fifo_level, q.size());
      check_eq("ovf",      overflow_err, m_ovf);
      check_eq("busy",     busy, m_active || (q.size() > 0));
      if (bus.rot_en_out)
        $display("beat t=%0t idx=%0d last=%0b quad=%0d x=%h y=%h dir=%h",
                 $time, bus.ch_idx_out, bus.last_out, bus.rot_quad_out,
                 bus.rot_xin_out, bus.rot_yin_out, bus.rot_microRot_out);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
    bus.s_xin = DW'($urandom);
    bus.s_yin = DW'($urandom);
  endtask

  task automatic push_word(input logic [ST-1:0] d, input logic [1:0] qd, input int c);
    bus.vec_opvld_in        = 1'b1;
    bus.vec_microRot_dir_in = d;
    bus.vec_quad_in         = qd;
    bus.vec_ch_count_in     = CW'(c);
    tick();
    bus.vec_opvld_in        = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    bus.vec_opvld_in = 0; bus.vec_microRot_dir_in = '0; bus.vec_quad_in = '0;
    bus.vec_ch_count_in = '0; bus.s_valid = 0; bus.s_xin = '0; bus.s_yin = '0;
    tick();
    checking = 1;
    tick();
    reset = 0;
    tick();

    // Single word, three channels, s_valid held high
    bus.s_valid = 1;
    push_word(16'hA5C3, 2'd2, 3);
    check_eq("sready_T1", bus.s_ready, 0);
    tick();
    check_eq("sready_T2", bus.s_ready, 1);
    run(8);
    check_eq("idle_after_word", busy, 0);

    // Back-to-back single-channel words for skew check
    push_word(16'h0001, 2'd1, 1);
    push_word(16'hFFFE, 2'd3, 1);
    run(22);

    // Fill the FIFO with s_valid low, overflow, then push-while-full with pop
    bus.s_valid = 0;
    for (int i = 0; i < 6; i++) push_word(ST'($urandom), 2'(i), 2);
    check_eq("full_level", fifo_level, FD);
    check_eq("full_ovf", overflow_err, 1);
    bus.s_valid = 1;
    tick();
    push_word(16'h1234, 2'd0, 2);
    check_eq("push_pop_level", fifo_level, FD);
    check_eq("push_pop_ovf", overflow_err, 1);
    run(30);

    // Count normalisation: 0 and 7 both mean four beats
    push_word(16'h0F0F, 2'd1, 0);
    push_word(16'hF0F0, 2'd2, 7);
    run(14);

    // Gappy s_valid: 1,0,1,1
    bus.s_valid = 0;
    push_word(16'h3C3C, 2'd3, 3);
    tick();
    bus.s_valid = 1; tick();
    bus.s_valid = 0; tick();
    bus.s_valid = 1; tick();
    tick();
    run(4);

    // Reset mid-replay with two words queued
    push_word(16'hAAAA, 2'd1, 4);
    push_word(16'h5555, 2'd2, 4);
    push_word(16'h9999, 2'd3, 4);
    reset = 1; tick();
    reset = 0;
    check_eq("rst_level", fifo_level, 0);
    check_eq("rst_en", bus.rot_en_out, 0);
    check_eq("rst_dir", bus.rot_microRot_out, 0);
    run(20);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      bus.vec_opvld_in        = ($urandom_range(0, 5) == 0);
      bus.vec_microRot_dir_in = ST'($urandom);
      bus.vec_quad_in         = 2'($urandom);
      bus.vec_ch_count_in     = CW'($urandom);
      bus.s_valid             = ($urandom_range(0, 9) < 7);
      reset                   = ($urandom_range(0, 599) == 0);
      tick();
    end
    bus.vec_opvld_in = 0;
    reset = 0;
    bus.s_valid = 1;
    run(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
